// File: rtl/pwm_demod_averager_pkg.sv
// Shared types, widths and width helpers for the PWM lock-in averager.
package pwm_demod_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int ADC_W = 12;

  function automatic int sum_w(input int log2_s);
    return ADC_W + log2_s;
  endfunction

  function automatic int acc_w(input int log2_s, input int log2_p);
    return sum_w(log2_s) + log2_p;
  endfunction

endpackage

// File: rtl/pwm_demod_averager_if.sv
// Result stream of the averager.
// A word transfers on every clock edge where out_valid && out_ready; the master
// holds out_data and out_valid stable while out_valid is high and out_ready low.
interface pwm_demod_averager_if;
  import pwm_demod_pkg::*;

  logic [ADC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/pwm_demod_averager_half_acc.sv
// One half-period accumulator: skips SETTLE samples, sums the next 2^LOG2_S,
// ignores the rest. 'clear' restarts the half and may coincide with a sample.
module pwm_demod_half_acc
  import pwm_demod_pkg::*;
#(
  parameter int LOG2_S = 2,
  parameter int SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      sample_valid,
  input  logic [ADC_W-1:0]          sample_data,
  output logic [sum_w(LOG2_S)-1:0]  sum,
  output logic                      full
);

  localparam int SW    = sum_w(LOG2_S);
  localparam int LIMIT = SETTLE + (1 << LOG2_S);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [SW-1:0]    sum_base;

  // A sample in the clear cycle is the first sample of the new half.
  always_comb begin
    cnt_base = clear ? '0 : cnt;
    sum_base = clear ? '0 : sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sum <= '0;
    end else begin
      cnt <= cnt_base;
      sum <= sum_base;
      if (sample_valid && (cnt_base < CNT_W'(LIMIT))) begin
        cnt <= cnt_base + 1'b1;
        if (cnt_base >= CNT_W'(SETTLE)) sum <= sum_base + SW'(sample_data);
      end
    end
  end

  assign full = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/pwm_demod_averager.sv
// PWM lock-in averager: per-period ON-minus-OFF mean, clamped at zero,
// averaged over 2^LOG2_P periods and offered on a valid/ready stream.
module pwm_demod_averager
  import pwm_demod_pkg::*;
#(
  parameter int LOG2_S = 2,
  parameter int SETTLE = 1,
  parameter int LOG2_P = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             switch_pwm,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample_data,
  pwm_demod_averager_if.master res,
  output logic             short_pulse,
  output logic             overrun_pulse,
  output state_t           fsm_state
);

  localparam int SW = sum_w(LOG2_S);
  localparam int AW = acc_w(LOG2_S, LOG2_P);

  logic   phase_q, rise, fall;
  state_t state, state_next;
  logic   on_en, off_en, close;

  logic [SW-1:0] on_sum, off_sum, diff, diff_q;
  logic          on_full, off_full, close_q, wrap;
  logic [AW-1:0] acc, acc_sum;
  logic [LOG2_P-1:0] period_cnt;
  logic [ADC_W-1:0]  out_data_q;
  logic              out_valid_q;

  assign rise = switch_pwm & ~phase_q;
  assign fall = ~switch_pwm & phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SYNC;
      phase_q <= 1'b0;
    end else begin
      state   <= state_next;
      phase_q <= switch_pwm;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC:    if (rise) state_next = ON;
      ON:      if (fall) state_next = OFF;
      OFF:     if (rise) state_next = ON;
      default: state_next = SYNC;
    endcase
  end

  // Gating on the next state routes an edge-cycle sample into the new half.
  always_comb begin
    on_en  = sample_valid && (state_next == ON);
    off_en = sample_valid && (state_next == OFF);
    close  = (state == OFF) && rise;
  end

  assign fsm_state = state;

  pwm_demod_half_acc #(.LOG2_S(LOG2_S), .SETTLE(SETTLE)) u_on_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (rise),
    .sample_valid (on_en),
    .sample_data  (sample_data),
    .sum          (on_sum),
    .full         (on_full)
  );

  pwm_demod_half_acc #(.LOG2_S(LOG2_S), .SETTLE(SETTLE)) u_off_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (fall),
    .sample_valid (off_en),
    .sample_data  (sample_data),
    .sum          (off_sum),
    .full         (off_full)
  );

  assign diff    = (on_sum > off_sum) ? (on_sum - off_sum) : '0;
  assign acc_sum = acc + AW'(diff_q);
  assign wrap    = close_q && (&period_cnt);

  // Sums are still the closing period's during the close cycle; capture them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_pulse <= 1'b0;
      close_q     <= 1'b0;
      diff_q      <= '0;
    end else begin
      short_pulse <= close && !(on_full && off_full);
      close_q     <= close && on_full && off_full;
      if (close) diff_q <= diff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      period_cnt <= '0;
    end else if (close_q) begin
      period_cnt <= period_cnt + 1'b1;
      acc        <= wrap ? '0 : acc_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      overrun_pulse <= 1'b0;
    end else begin
      overrun_pulse <= 1'b0;
      if (wrap) begin
        if (out_valid_q && !res.out_ready) begin
          overrun_pulse <= 1'b1;
        end else begin
          out_data_q  <= acc_sum[AW-1 -: ADC_W];
          out_valid_q <= 1'b1;
        end
      end else if (out_valid_q && res.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign res.out_data  = out_data_q;
  assign res.out_valid = out_valid_q;

endmodule
